// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with baud divider, parity and stop select; UART_TX_BREAK_EN adds send_break
module uart_tx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
`ifdef UART_TX_BREAK_EN
  input  logic                        send_break,
`endif
  input  logic [DATA_BITS-1:0]        tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  input  logic [DIV_W-1:0]            baud_div,
  input  logic [1:0]                  parity_mode,
  input  logic                        two_stop,
  output logic                        TX,
  output logic                        busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP
`ifdef UART_TX_BREAK_EN
    , BRK, MAB
`endif
  } state_t;
  state_t state_q, state_d;
  logic [DATA_BITS-1:0] fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic par_q, par_d, par_en_q, par_en_d, two_q, two_d, done_q, done_d;
  logic [DIV_W-1:0] div_q, div_d, baud_q, baud_d, div_eff;
  logic [3:0] bit_q, bit_d;
  logic push, pop, bit_end, brk_req, brk_line;
`ifdef UART_TX_BREAK_EN
  assign brk_req = send_break;
  assign brk_line = state_q == BRK;
`else
  assign brk_req = 1'b0;
  assign brk_line = 1'b0;
`endif
  assign tx_ready = cnt_q != CW'(FIFO_DEPTH);
  assign push = tx_valid && tx_ready;
  assign pop = state_q == IDLE && cnt_q != '0 && !brk_req;
  assign bit_end = baud_q == div_q - 1'b1;
  assign div_eff = baud_div == '0 ? DIV_W'(1) : baud_div;
  assign TX = (state_q == START) ? 1'b0 :
              (state_q == DATA) ? shift_q[0] :
              (state_q == PARITY) ? par_q : !brk_line;
  assign busy = state_q != IDLE;
  assign tx_done = done_q;
  assign fifo_count = cnt_q;
  always_comb begin
    state_d = state_q;
    wr_d = push ? wr_q + 1'b1 : wr_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    shift_d = shift_q;
    par_d = par_q;
    par_en_d = par_en_q;
    two_d = two_q;
    div_d = div_q;
    bit_d = bit_q;
    done_d = 1'b0;
    baud_d = (state_q == IDLE || bit_end) ? '0 : baud_q + 1'b1;
    case (state_q)
      IDLE: begin
        bit_d = '0;
`ifdef UART_TX_BREAK_EN
        if (send_break) begin
          state_d = BRK;
          div_d = div_eff;
        end else
`endif
        if (pop) begin
          state_d = START;
          shift_d = fifo_q[rd_q];
          par_d = ^fifo_q[rd_q] ^ (parity_mode == 2'b10);
          par_en_d = ^parity_mode;
          two_d = two_stop;
          div_d = div_eff;
        end
      end
      START: state_d = bit_end ? DATA : START;
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          bit_d = bit_q + 1'b1;
          if (bit_q == 4'(DATA_BITS - 1)) begin
            bit_d = '0;
            state_d = par_en_q ? PARITY : STOP;
          end
        end
      end
      PARITY: state_d = bit_end ? STOP : PARITY;
      STOP: begin
        if (bit_end) begin
          if (two_q && bit_q == '0) begin
            bit_d = 4'd1;
          end else begin
            state_d = IDLE;
            done_d = 1'b1;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      BRK: begin
        if (bit_end) begin
          if (bit_q == 4'(DATA_BITS + 1) && !send_break) begin
            state_d = MAB;
            bit_d = '0;
          end else if (bit_q != 4'(DATA_BITS + 1)) begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      MAB: state_d = bit_end ? IDLE : MAB;
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_q] <= tx_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      shift_q <= '0;
      par_q <= 1'b0;
      par_en_q <= 1'b0;
      two_q <= 1'b0;
      div_q <= '0;
      baud_q <= '0;
      bit_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      shift_q <= shift_d;
      par_q <= par_d;
      par_en_q <= par_en_d;
      two_q <= two_d;
      div_q <= div_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo; break test runs when UART_TX_BREAK_EN is defined
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  logic rst, tx_valid, two_stop, TX, busy, tx_done, tx_ready;
  logic [7:0] tx_data;
  logic [15:0] baud_div;
  logic [1:0] parity_mode;
  logic [3:0] fifo_count;
`ifdef UART_TX_BREAK_EN
  logic send_break;
`endif
  int errors = 0;
  int checks = 0;
  logic [255:0] wave, expw;
  int done_n, done_at, p;
  logic [7:0] rxd [9];
  logic [7:0] d;
  always #5 clk = ~clk;
  uart_tx_fifo dut (
    .clk(clk),
    .rst(rst),
`ifdef UART_TX_BREAK_EN
    .send_break(send_break),
`endif
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .baud_div(baud_div),
    .parity_mode(parity_mode),
    .two_stop(two_stop),
    .TX(TX),
    .busy(busy),
    .tx_done(tx_done),
    .fifo_count(fifo_count)
  );
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic void add_frame(inout logic [255:0] w, inout int pos, input logic [7:0] dat,
                                    input int div, input logic [1:0] pm, input logic ts);
    logic [11:0] bits;
    int nb;
    bits = '0;
    for (int b = 0; b < 8; b++) bits[b+1] = dat[b];
    nb = 9;
    if (pm == 2'b01 || pm == 2'b10) begin
      bits[nb] = ^dat ^ (pm == 2'b10);
      nb++;
    end
    bits[nb] = 1'b1;
    nb++;
    if (ts) begin
      bits[nb] = 1'b1;
      nb++;
    end
    for (int i = 0; i < nb; i++)
      for (int k = 0; k < div; k++) begin
        w[pos] = bits[i];
        pos++;
      end
  endfunction
  task automatic push(input logic [7:0] v);
    @(negedge clk);
    tx_data = v;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask
  task automatic capture(input int n);
    int t;
    t = 0;
    while (TX !== 1'b0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("start seen", 256'(t < 300), 256'(1));
    wave = '1;
    done_n = 0;
    done_at = -1;
    for (int i = 0; i < n; i++) begin
      wave[i] = TX;
      if (tx_done) begin
        if (done_n == 0) done_at = i;
        done_n++;
      end
      @(negedge clk);
    end
  endtask
  task automatic rx_byte(output logic [7:0] v);
    int t;
    t = 0;
    v = '0;
    while (TX !== 1'b0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("rx start", 256'(t < 300), 256'(1));
    repeat (baud_div / 2) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      repeat (baud_div) @(negedge clk);
      v[b] = TX;
    end
    repeat (baud_div) @(negedge clk);
    check("rx stop", TX, 1'b1);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    tx_valid = 1'b0;
    tx_data = '0;
    baud_div = 16'd4;
    parity_mode = 2'b00;
    two_stop = 1'b0;
`ifdef UART_TX_BREAK_EN
    send_break = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset TX", TX, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset tx_done", tx_done, 1'b0);
    check("reset count", fifo_count, 4'd0);
    check("reset ready", tx_ready, 1'b1);
    @(negedge clk);
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("lat count N+1", fifo_count, 4'd1);
    check("lat busy N+1", busy, 1'b0);
    @(negedge clk);
    check("lat busy N+2", busy, 1'b1);
    check("lat TX N+2", TX, 1'b0);
    check("lat count N+2", fifo_count, 4'd0);
    capture(48);
    expw = '1;
    p = 0;
    add_frame(expw, p, 8'hA5, 4, 2'b00, 1'b0);
    check("8N1 wave", wave, expw);
    check("8N1 done count", done_n, 1);
    check("8N1 done at", done_at, 40);
    parity_mode = 2'b01;
    push(8'hA5);
    capture(50);
    expw = '1;
    p = 0;
    add_frame(expw, p, 8'hA5, 4, 2'b01, 1'b0);
    check("even wave", wave, expw);
    check("even parity bit", wave[37], 1'b0);
    check("even done at", done_at, 44);
    parity_mode = 2'b10;
    push(8'hA5);
    capture(50);
    expw = '1;
    p = 0;
    add_frame(expw, p, 8'hA5, 4, 2'b10, 1'b0);
    check("odd wave", wave, expw);
    check("odd parity bit", wave[37], 1'b1);
    check("odd done at", done_at, 44);
    parity_mode = 2'b00;
    two_stop = 1'b1;
    @(negedge clk);
    tx_data = 8'h00;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'hFF;
    @(negedge clk);
    tx_valid = 1'b0;
    capture(100);
    expw = '1;
    p = 0;
    add_frame(expw, p, 8'h00, 4, 2'b00, 1'b1);
    p++;
    add_frame(expw, p, 8'hFF, 4, 2'b00, 1'b1);
    check("2stop b2b wave", wave, expw);
    check("2stop done count", done_n, 2);
    check("2stop done at", done_at, 44);
    two_stop = 1'b0;
    baud_div = 16'd0;
    push(8'hC3);
    capture(16);
    expw = '1;
    p = 0;
    add_frame(expw, p, 8'hC3, 1, 2'b00, 1'b0);
    check("div0 wave", wave, expw);
    check("div0 done at", done_at, 10);
    baud_div = 16'd4;
    repeat (3) @(negedge clk);
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (i == 9) begin
            check("full count", fifo_count, 4'd8);
            check("full ready", tx_ready, 1'b0);
          end
          tx_data = 8'(i + 1);
          tx_valid = 1'b1;
        end
        @(negedge clk);
        tx_valid = 1'b0;
        check("full no overwrite count", fifo_count, 4'd8);
      end
      begin
        for (int j = 0; j < 9; j++) rx_byte(rxd[j]);
      end
    join
    for (int j = 0; j < 9; j++) check("fifo order", rxd[j], 8'(j + 1));
    repeat (20) @(negedge clk);
    check("no tenth frame busy", busy, 1'b0);
    check("drained count", fifo_count, 4'd0);
    push(8'h3C);
    push(8'h77);
    repeat (14) @(negedge clk);
    check("mid data busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort TX", TX, 1'b1);
    check("abort busy", busy, 1'b0);
    check("abort count", fifo_count, 4'd0);
    check("abort ready", tx_ready, 1'b1);
    push(8'h5A);
    rx_byte(d);
    check("post reset byte", d, 8'h5A);
    repeat (30) @(negedge clk);
    check("discarded busy", busy, 1'b0);
    check("discarded count", fifo_count, 4'd0);
`ifdef UART_TX_BREAK_EN
    baud_div = 16'd2;
    @(negedge clk);
    send_break = 1'b1;
    tx_data = 8'h55;
    tx_valid = 1'b1;
    @(negedge clk);
    send_break = 1'b0;
    tx_valid = 1'b0;
    check("break queued count", fifo_count, 4'd1);
    capture(44);
    expw = '1;
    for (int i = 0; i < 20; i++) expw[i] = 1'b0;
    p = 23;
    add_frame(expw, p, 8'h55, 2, 2'b00, 1'b0);
    check("break wave", wave, expw);
    check("break done count", done_n, 1);
    check("break done at", done_at, 43);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
